spi_cfg_master: RTL and testbench

- Two-requester SPI write master that configures the chip's SPI register file (output-enable, PWM-enable and PWM-duty registers) over a 4-wire link.
- Arbitrates round-robin between two on-chip requesters, each offering {addr, data} writes on a valid/ready handshake.
- Serialises each accepted write as one 16-bit mode-0 frame, MSB first: bit15 = 1 (write), [14:8] = 7-bit address, [7:0] = data.

---
 rtl/spi_cfg_master.sv | 124 ++++++++++++
 tb/tb_spi_cfg_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_master.sv
// Round-robin SPI write master for the chip's register file: each accepted
// {addr, data} write goes out as one 16-bit mode-0 frame {1'b1, addr, data}, MSB first.
module spi_cfg_master #(
    parameter int CLK_DIV = 50,
    parameter int GAP_CYC = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic       spi_ncs,
    output logic       spi_sclk,
    output logic       spi_copi
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

    state_t           state, next_state;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [4:0]       bit_cnt;
    logic [15:0]      shift_reg;
    logic             rr_ptr;
    logic             cur_id;
    logic             grant0, grant1, xfer0, xfer1, phase_end;

    // rr_ptr only matters when both requesters are valid at the same time
    assign grant0     = req0_valid && (!req1_valid || !rr_ptr);
    assign grant1     = req1_valid && (!req0_valid || rr_ptr);
    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;
    assign xfer0      = req0_valid && req0_ready;
    assign xfer1      = req1_valid && req1_ready;
    assign phase_end  = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        spi_ncs    = 1'b1;
        spi_sclk   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (xfer0 || xfer1) next_state = SETUP;
            end
            SETUP: begin
                spi_ncs = 1'b0;
                if (phase_end) next_state = SHIFT_HI;
            end
            SHIFT_HI: begin
                spi_ncs  = 1'b0;
                spi_sclk = 1'b1;
                if (phase_end) next_state = SHIFT_LO;
            end
            SHIFT_LO: begin
                spi_ncs = 1'b0;
                if (phase_end) next_state = (bit_cnt == 5'd16) ? HOLD : SHIFT_HI;
            end
            HOLD: begin
                spi_ncs = 1'b0;
                if (phase_end) next_state = GAP;
            end
            GAP: begin
                done = (gap_cnt == '0);
                if (gap_cnt == GAP_LAST) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The shift happens on the falling sclk edge, so copi only moves while sclk is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rr_ptr    <= 1'b0;
            cur_id    <= 1'b0;
        end else begin
            if (next_state != state) begin
                div_cnt <= '0;
            end else if (state != IDLE && state != GAP) begin
                div_cnt <= div_cnt + 1'b1;
            end
            gap_cnt <= (state == GAP && next_state == GAP) ? gap_cnt + 1'b1 : '0;
            if (xfer0 || xfer1) begin
                shift_reg <= xfer1 ? {1'b1, req1_addr, req1_data} : {1'b1, req0_addr, req0_data};
                bit_cnt   <= '0;
                rr_ptr    <= xfer0;
                cur_id    <= xfer1;
            end else if (state == SHIFT_HI && phase_end) begin
                shift_reg <= {shift_reg[14:0], 1'b0};
                bit_cnt   <= bit_cnt + 1'b1;
            end
        end
    end

    assign spi_copi = shift_reg[15];
    assign done_id  = done & cur_id;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: timeline reference model checked every cycle, scripted
// scenarios with literal expectations, then randomized two-requester traffic.
module tb_spi_cfg_master;
    localparam int CD    = 4;
    localparam int GP    = 8;
    localparam int FRAME = 34 * CD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0v = 1'b0, r1v = 1'b0;
    logic [6:0] r0a = '0, r1a = '0;
    logic [7:0] r0d = '0, r1d = '0;
    logic       req0_ready, req1_ready, busy, done, done_id, spi_ncs, spi_sclk, spi_copi;

    always #5 clk = ~clk;

    spi_cfg_master #(.CLK_DIV(CD), .GAP_CYC(GP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(req0_ready), .req0_addr(r0a), .req0_data(r0d),
        .req1_valid(r1v), .req1_ready(req1_ready), .req1_addr(r1a), .req1_data(r1d),
        .busy(busy), .done(done), .done_id(done_id),
        .spi_ncs(spi_ncs), .spi_sclk(spi_sclk), .spi_copi(spi_copi)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference model state: the current frame is described only by its
    // acceptance cycle, its 16-bit word and the requester id.
    int         cyc = 0, m_free = 0, m_start = 0;
    bit         m_rr = 1'b0, m_id = 1'b0, chk_en = 1'b0;
    logic [15:0] m_frame = '0;
    bit         hs0 = 1'b0, hs1 = 1'b0, gap_armed = 1'b0;
    logic       prev_sclk = 1'b0, prev_ncs = 1'b1, prev_copi = 1'b0;
    logic [15:0] rx_sh = '0;
    logic [15:0] rx_q[$];
    logic       id_q[$];
    int         acc_cyc = 0, done_cyc = 0, done_cnt = 0;
    int         low_cnt = 0, high_cnt = 0, last_low = 0;

    always @(negedge clk) begin : model
        int   t, u, k;
        bit   idle;
        logic e_r0, e_r1, e_busy, e_ncs, e_sclk, e_copi, e_done, e_did;
        cyc++;
        idle = (cyc >= m_free);
        e_r0 = 1'b0; e_r1 = 1'b0; e_busy = 1'b0; e_ncs = 1'b1;
        e_sclk = 1'b0; e_copi = 1'b0; e_done = 1'b0; e_did = 1'b0;
        if (idle) begin
            e_r0 = r0v && (!r1v || !m_rr);
            e_r1 = r1v && (!r0v || m_rr);
        end else begin
            t      = cyc - m_start;
            u      = t - 1 - CD;
            k      = (t - 1) / (2 * CD);
            e_busy = (t <= FRAME + GP);
            e_ncs  = !(t <= FRAME);
            e_sclk = (u >= 0) && (u < 32 * CD) && (((u / CD) % 2) == 0);
            e_copi = (t <= FRAME && k < 16) ? m_frame[15-k] : 1'b0;
            e_done = (t == FRAME + 1);
            e_did  = e_done ? m_id : 1'b0;
        end
        if (chk_en) begin
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("busy", busy, e_busy);
            chk("spi_ncs", spi_ncs, e_ncs);
            chk("spi_sclk", spi_sclk, e_sclk);
            chk("spi_copi", spi_copi, e_copi);
            chk("done", done, e_done);
            chk("done_id", done_id, e_did);
            if (prev_sclk && spi_sclk) chk("copi_stable_sclk_high", spi_copi, prev_copi);
            if (!prev_sclk && spi_sclk) rx_sh = {rx_sh[14:0], spi_copi};
            if (prev_ncs && !spi_ncs) begin
                if (gap_armed) chk("ncs_gap_min", high_cnt >= GP, 1'b1);
                gap_armed = 1'b0;
                rx_sh     = '0;
                low_cnt   = 0;
            end
            if (!spi_ncs) low_cnt++;
            if (!prev_ncs && spi_ncs) begin
                rx_q.push_back(rx_sh);
                last_low = low_cnt;
                high_cnt = 0;
            end
            if (spi_ncs) high_cnt++;
            if (done) begin
                id_q.push_back(done_id);
                done_cyc  = cyc;
                done_cnt++;
                gap_armed = 1'b1;
            end
        end
        hs0 = rst_n && r0v && req0_ready;
        hs1 = rst_n && r1v && req1_ready;
        if (!rst_n) begin
            m_rr      = 1'b0;
            m_free    = cyc + 1;
            gap_armed = 1'b0;
        end else if (idle && (e_r0 || e_r1)) begin
            m_start = cyc;
            m_free  = cyc + FRAME + GP + 1;
            m_id    = e_r1;
            m_rr    = !e_r1;
            m_frame = e_r1 ? {1'b1, r1a, r1d} : {1'b1, r0a, r0d};
            acc_cyc = cyc;
        end
        prev_sclk = spi_sclk;
        prev_ncs  = spi_ncs;
        prev_copi = spi_copi;
    end

    function automatic logic [15:0] rx_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 16'hxxxx;
    endfunction

    function automatic logic id_at(input int i);
        return (i < id_q.size()) ? id_q[i] : 1'bx;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; r0v = 1'b0; r1v = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rx_q.delete();
        id_q.delete();
    endtask

    task automatic send(input bit id, input logic [6:0] a, input logic [7:0] d, output int waits);
        bit ok = 1'b0;
        waits = 0;
        @(posedge clk); #1;
        if (id) begin r1a = a; r1d = d; r1v = 1'b1; end
        else    begin r0a = a; r0d = d; r0v = 1'b1; end
        for (int i = 0; i < 4 * (FRAME + GP); i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
            waits++;
        end
        @(posedge clk); #1;
        r0v = 1'b0; r1v = 1'b0;
        if (!ok) timeout("send_handshake");
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 2 * (FRAME + GP); i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        if (!ok) timeout("wait_done");
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 4 * (FRAME + GP); i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        if (!ok) timeout("wait_idle");
    endtask

    task automatic serve(input int n0, input int n1);
        int left0 = n0;
        int left1 = n1;
        int guard = 0;
        @(posedge clk); #1;
        r0v = (n0 > 0); r1v = (n1 > 0);
        while ((left0 > 0 || left1 > 0) && guard < 12 * (FRAME + GP)) begin
            @(negedge clk);
            guard++;
            if (r0v && req0_ready) left0--;
            if (r1v && req1_ready) left1--;
            @(posedge clk); #1;
            if (left0 == 0) r0v = 1'b0;
            if (left1 == 0) r1v = 1'b0;
        end
        r0v = 1'b0; r1v = 1'b0;
        if (left0 > 0 || left1 > 0) timeout("serve");
    endtask

    initial begin
        int w, snap;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_ncs", spi_ncs, 1'b1);
        chk("rst_sclk", spi_sclk, 1'b0);
        chk("rst_copi", spi_copi, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", {done, done_id}, 2'b00);
        chk("rst_ready", {req0_ready, req1_ready}, 2'b00);

        // Single req0 write
        send(1'b0, 7'h00, 8'hA5, w);
        wait_done();
        chk("t1_nframes", rx_q.size(), 1);
        chk("t1_frame", rx_at(0), 16'h80A5);
        chk("t1_ncs_low", last_low, 136);
        chk("t1_accept_to_done", done_cyc - acc_cyc - 1, 136);
        chk("t1_done_id", id_at(0), 1'b0);
        wait_idle();

        // Both valid straight out of reset
        do_reset();
        r0a = 7'h02; r0d = 8'h3C; r1a = 7'h04; r1d = 8'h80;
        serve(1, 1);
        wait_idle();
        chk("t2_frame0", rx_at(0), 16'h823C);
        chk("t2_frame1", rx_at(1), 16'h8480);
        chk("t2_ids", {id_at(0), id_at(1)}, 2'b01);

        // Both held for four frames
        rx_q.delete(); id_q.delete();
        serve(2, 2);
        wait_idle();
        chk("t3_ids", {id_at(0), id_at(1), id_at(2), id_at(3)}, 4'b0101);
        chk("t3_frame3", rx_at(3), 16'h8480);

        // Lone requester is granted without waiting, whatever rr_ptr says
        do_reset();
        send(1'b0, 7'h10, 8'h01, w); wait_idle();
        send(1'b0, 7'h11, 8'h02, w); chk("t4_req0_again_immediate", w, 0); wait_idle();
        send(1'b1, 7'h12, 8'h03, w); chk("t4_req1_immediate", w, 0); wait_idle();
        send(1'b1, 7'h13, 8'h04, w); chk("t4_req1_again_immediate", w, 0); wait_idle();
        chk("t4_ids", {id_at(0), id_at(1), id_at(2), id_at(3)}, 4'b0011);
        chk("t4_frame2", rx_at(2), 16'h9203);

        // Reset while bit 7 is on the wire
        @(posedge clk); #1;
        r0a = 7'h55; r0d = 8'h5A; r0v = 1'b1;
        @(negedge clk);
        chk("t5_accept", req0_ready, 1'b1);
        @(posedge clk); #1 r0v = 1'b0;
        repeat (67) @(posedge clk);
        #1 rst_n = 1'b0;
        snap = done_cnt;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ncs", spi_ncs, 1'b1);
        chk("t5_sclk_copi", {spi_sclk, spi_copi}, 2'b00);
        chk("t5_busy", busy, 1'b0);
        repeat (FRAME + GP) @(posedge clk);
        chk("t5_no_done", done_cnt, snap);
        rx_q.delete(); id_q.delete();
        send(1'b1, 7'h33, 8'hC3, w);
        wait_done();
        chk("t5_fresh_frame", rx_at(0), 16'hB3C3);
        wait_idle();

        // All-ones frame
        rx_q.delete();
        send(1'b1, 7'h7F, 8'hFF, w);
        wait_done();
        chk("t6_frame", rx_at(0), 16'hFFFF);
        wait_idle();

        // Random traffic, including requests withdrawn before being granted
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (r0v) begin
                if (hs0 || $urandom_range(0, 29) == 0) r0v = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                r0a = 7'($urandom); r0d = 8'($urandom); r0v = 1'b1;
            end
            if (r1v) begin
                if (hs1 || $urandom_range(0, 29) == 0) r1v = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                r1a = 7'($urandom); r1d = 8'($urandom); r1v = 1'b1;
            end
        end
        @(posedge clk); #1;
        r0v = 1'b0; r1v = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
